fp_mul_share_arbiter: RTL
=========================

# fp_mul_share_arbiter

Round-robin arbiter that time-shares one pipelined `fp_mul` instance between `NUM_REQ` requesters, such as the two channel datapaths of the final adder. It accepts at most one operand pair per enabled cycle and drives the shared multiplier. A tag pipeline tracks each operation so every result is routed back to the requester that issued it. Throughput is one multiply per cycle; no requester is starved.

## Interface
- `DATA_WIDTH`, 32: float operand/result width.
- `NUM_REQ`, 2: number of requesters, 2..8.
- `MUL_LATENCY`, 6: enabled clock edges from operands applied to `mul_result` valid.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: global enable; when 0, no state advances.
- `req_valid` in NUM_REQ: per-requester operand pair available.
- `req_dataa` in NUM_REQ*DATA_WIDTH: operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_datab` in NUM_REQ*DATA_WIDTH: operand B, same packing.
- `req_ready` out NUM_REQ: combinational one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid` out NUM_REQ: registered one-cycle pulse, result for requester i.
- `resp_result` out DATA_WIDTH: registered result, valid when any `resp_valid` bit is set.
- `busy` out 1: registered; 1 while any tag-pipeline stage is valid.
- `mul_aclr` out 1: equals `rst`.
- `mul_clk_en` out 1: equals `clk_en & ~rst`.
- `mul_dataa`, `mul_datab` out DATA_WIDTH: muxed operands of the granted requester; 0 when no grant.
- `mul_result` in DATA_WIDTH: shared multiplier output.

## Operation
- State: `last_grant` pointer (ID_WIDTH = clog2(NUM_REQ), minimum 1), and tag pipeline `tag[0..MUL_LATENCY-1]`. Each tag stage is {valid, id}.
- Arbitration is combinational. Search order is `last_grant+1`, `last_grant+2`, … mod NUM_REQ. The first requester with `req_valid` set is chosen.
- `req_ready` is one-hot for the chosen requester only when `clk_en=1` and `rst=0`; otherwise it is all zeros.
- On an accepted transfer, `last_grant` takes the granted id. With no transfer, `last_grant` holds.
- On each edge with `clk_en=1`:
  - `tag[0]` takes {transfer, granted id}.
  - `tag[k+1]` takes `tag[k]`.
- On each edge, regardless of `clk_en`:
  - `resp_valid` takes the one-hot of `tag[L-1].id` when `clk_en & tag[L-1].valid`; otherwise 0.
  - `resp_result` takes `mul_result` under the same condition; otherwise it holds its value.
- `busy` takes the OR of all tag valid bits, computed after the update.
- There is no response backpressure: requesters must consume `resp_valid` pulses.
- Reset values: `last_grant`=NUM_REQ-1, so requester 0 wins first. All tag valids=0, `resp_valid`=0, `resp_result`=0, `busy`=0.

## Timing
- Transfer in cycle T: `resp_valid` is high in cycle T+MUL_LATENCY+1, with no `clk_en`-low edges in between.
- Each `clk_en`=0 edge inside that window adds one cycle. The tag and the multiplier freeze together, so the pairing is preserved.
- Sustained throughput is 1 transfer per enabled cycle.
- Fairness: if all requesters are valid every cycle, grants rotate 0,1,…,NUM_REQ-1,0,…
- A single active requester is granted every cycle.
- Simultaneous transfer and response in the same cycle are independent; both complete.
- `rst` mid-operation: all in-flight operations are discarded with no `resp_valid` for them. `mul_aclr` clears the multiplier. Arbitration resumes with requester 0 priority on the first cycle after `rst` falls.
- `req_valid` dropping without a grant is allowed. Operands only need to be stable in the cycle of transfer.

## Test plan
- Single request: reset, then req 0 with a=2.0 (0x40000000) and b=3.0 (0x40400000) in cycle 5. Expect `resp_valid`=01 and `resp_result`=0x40C00000 in cycle 12. `busy` is high from cycle 6 to cycle 11.
- Contention: both requests held valid for 4 cycles with distinct operands. Expect grants 0,1,0,1, then four responses on consecutive cycles with ids 0,1,0,1, each routed correctly.
- Stall: issue req 1, then hold `clk_en`=0 for 3 cycles mid-flight. Expect the response 3 cycles later than nominal, with the correct value. `req_ready` is 0 during the stall.
- Reset mid-flight: issue 3 operations, then assert `rst` for 1 cycle two cycles later. Expect no `resp_valid` afterwards, `busy`=0, and a new request from req 1 granted immediately.
- Round-robin pointer: req 1 only for 1 transfer, then both valid. Expect requester 0 granted next.
- Random: a bench with NUM_REQ=4 drives random valids and operands against a reference model. Expect all results matched, no loss, and no starvation beyond NUM_REQ-1 cycles.

Source files
------------

// File: rtl/fp_mul_share_arbiter.sv
// rtl/fp_mul_share_arbiter.sv - round-robin sharing of one pipelined fp_mul between requesters
// A tag pipeline that mirrors the multiplier latency routes each result back to its issuer.
module fp_mul_share_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dataa,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_datab,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          busy,
  output logic                          mul_aclr,
  output logic                          mul_clk_en,
  output logic [DATA_WIDTH-1:0]         mul_dataa,
  output logic [DATA_WIDTH-1:0]         mul_datab,
  input  logic [DATA_WIDTH-1:0]         mul_result
);

  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_WIDTH-1:0]    last_grant;
  logic [MUL_LATENCY-1:0] tag_valid;
  logic [MUL_LATENCY-1:0] tag_valid_next;
  logic [ID_WIDTH-1:0]    tag_id [MUL_LATENCY];

  logic                   arb_en;
  logic                   grant_found;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [ID_WIDTH-1:0]    idx;
  logic                   transfer;

  assign arb_en     = clk_en & ~rst;
  assign mul_aclr   = rst;
  assign mul_clk_en = clk_en & ~rst;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign transfer  = arb_en & grant_found;
  assign req_ready = transfer ? (NUM_REQ'(1) << grant_id) : '0;
  assign mul_dataa = transfer ? req_dataa[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mul_datab = transfer ? req_datab[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // The tag pipeline freezes with the multiplier so operand/result pairing survives stalls.
  always_comb begin
    tag_valid_next = tag_valid;
    if (clk_en) begin
      tag_valid_next = (tag_valid << 1) | MUL_LATENCY'(transfer);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= ID_WIDTH'(NUM_REQ - 1);
      tag_valid   <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tag_id[k] <= '0;
      end
      resp_valid  <= '0;
      resp_result <= '0;
      busy        <= 1'b0;
    end else begin
      if (clk_en) begin
        if (transfer) begin
          last_grant <= grant_id;
        end
        tag_valid <= tag_valid_next;
        tag_id[0] <= grant_id;
        for (int k = 1; k < MUL_LATENCY; k++) begin
          tag_id[k] <= tag_id[k-1];
        end
      end
      if (clk_en && tag_valid[MUL_LATENCY-1]) begin
        resp_valid  <= NUM_REQ'(1) << tag_id[MUL_LATENCY-1];
        resp_result <= mul_result;
      end else begin
        resp_valid  <= '0;
      end
      busy <= |tag_valid_next;
    end
  end

endmodule
